hd63701_irq_ctrl: RTL and testbench
===================================

HD63701_IRQ_CTRL -- requirements
Module: hd63701_irq_ctrl

Interface
REQ-001 SHALL have ports: mcu_clx2  in  1  sole clock, all state on rising edge.
REQ-002 SHALL have ports: mcu_rst  in  1  reset, synchronous, active-high.
REQ-003 SHALL have ports: nmi  in  1  non-maskable request, rising-edge sensitive.
REQ-004 SHALL have ports: irq1  in  1  external IRQ1, level, active-high.
REQ-005 SHALL have ports: ici, oci, toi, cmi, sci  in  1 each  IRQ2 sources (input capture, output compare, overflow, counter match, serial), level, active-high.
REQ-006 SHALL have ports: imask  in  1  CPU I flag; 1 masks IRQ1 and all IRQ2 sources.
REQ-007 SHALL have ports: ack  in  1  single-cycle pulse from core at vector fetch.
REQ-008 SHALL have ports: irq_req  out  1  request to core.
REQ-009 SHALL have ports: irq_vec  out  16  vector address of frozen winner.
REQ-010 SHALL have ports: irq_src  out  3  encoded winner: 0 none, 1 NMI, 2 IRQ1, 3 ICI, 4 OCI, 5 TOI, 6 CMI, 7 SCI.

Function
REQ-011 SHALL fix priority, highest first: NMI > IRQ1 > ICI > OCI > TOI > CMI > SCI.
REQ-012 SHALL use vectors: NMI $FFFC, IRQ1 $FFF8, ICI $FFF6, OCI $FFF4, TOI $FFF2, CMI $FFEC, SCI $FFF0.
REQ-013 SHALL register nmi each cycle; nmi=1 with previous sample 0 sets nmi_pend.
REQ-014 SHALL treat a source as eligible when: NMI if nmi_pend; others if level high and imask=0.
REQ-015 SHALL implement states IDLE, PEND, GAP.
REQ-016 IDLE: with any eligible source, SHALL latch winner into irq_src/irq_vec and go to PEND; irq_req=1 from the next cycle (1-cycle latency).
REQ-017 PEND: irq_req=1; irq_src/irq_vec SHALL stay frozen regardless of new higher-priority arrivals.
REQ-018 PEND with ack=1: SHALL go to GAP; if winner is NMI, clear nmi_pend in the same edge.
REQ-019 PEND with maskable winner and (imask=1 or winner level low) and ack=0: SHALL withdraw and return to IDLE, irq_req=0 next cycle.
REQ-020 A withdrawn request SHALL never drop nmi_pend.
REQ-021 GAP: irq_req=0 for exactly one cycle, then IDLE; irq_src=0 and irq_vec=$0000 whenever irq_req=0.
REQ-022 ack in IDLE or GAP SHALL be ignored.
REQ-023 An NMI edge arriving while nmi_pend=1 SHALL merge (no count).
REQ-024 An NMI edge arriving in PEND/GAP SHALL remain latched and be serviced on the next IDLE arbitration.
REQ-025 Controller SHALL NOT clear level sources; the peripheral clears its flag.

Reset
REQ-026 On mcu_rst=1 at a clock edge: state=IDLE, nmi_pend=0, nmi sample=1 (no false edge if nmi held high), irq_req=0, irq_src=0, irq_vec=$0000.
REQ-027 Reset mid-PEND SHALL abandon the request with no ack required.

Configuration
REQ-028 Macro HD63701_IRQ_SCI_EN defined: sci participates per REQ-011.
REQ-029 Macro HD63701_IRQ_SCI_EN undefined: sci input ignored; irq_src never 7; all else identical.

Structure
REQ-030 Package hd63701_irq_pkg SHALL hold source-code constants (0..7), vector constants, and the state enumeration.
REQ-031 Sub-module hd63701_irq_prienc SHALL be a combinational 7-input priority encoder returning source code and vector; the FSM stays in hd63701_irq_ctrl.

Verification
REQ-032 toi=1, imask=0 -> irq_req=1 one cycle later, irq_src=5, irq_vec=$FFF2; ack -> irq_req=0 for GAP, then re-request while toi stays high.
REQ-033 irq1 and sci high same cycle, imask=0 -> irq_src=2, irq_vec=$FFF8; after ack and irq1 low -> irq_src=7, irq_vec=$FFF0 (macro defined), no request (macro undefined).
REQ-034 oci pending in PEND, nmi rises -> irq_src stays 4 until ack; after GAP -> irq_src=1, irq_vec=$FFFC; ack clears nmi_pend; no further request.
REQ-035 cmi PEND, imask rises before ack -> irq_req=0 next cycle, irq_src=0; nmi held high through withdraw -> no NMI request.
REQ-036 nmi held high across mcu_rst release -> no request; nmi low then high -> one NMI request.
REQ-037 mcu_rst asserted during PEND for ici -> irq_req=0 next cycle; ack pulse in IDLE with no sources -> irq_req stays 0.

Source files
------------

// File: rtl/hd63701_irq_pkg.sv
`default_nettype none
// ============================================================================
// Module   : hd63701_irq_pkg
// Purpose  : Source codes, vector addresses and FSM states shared by the
//            HD63701 interrupt controller and its priority encoder.
// Revision : 1.0  initial release
// ============================================================================
package hd63701_irq_pkg;

  localparam logic [2:0] c_src_none = 3'd0;
  localparam logic [2:0] c_src_nmi  = 3'd1;
  localparam logic [2:0] c_src_irq1 = 3'd2;
  localparam logic [2:0] c_src_ici  = 3'd3;
  localparam logic [2:0] c_src_oci  = 3'd4;
  localparam logic [2:0] c_src_toi  = 3'd5;
  localparam logic [2:0] c_src_cmi  = 3'd6;
  localparam logic [2:0] c_src_sci  = 3'd7;

  localparam logic [15:0] c_vec_none = 16'h0000;
  localparam logic [15:0] c_vec_nmi  = 16'hFFFC;
  localparam logic [15:0] c_vec_irq1 = 16'hFFF8;
  localparam logic [15:0] c_vec_ici  = 16'hFFF6;
  localparam logic [15:0] c_vec_oci  = 16'hFFF4;
  localparam logic [15:0] c_vec_toi  = 16'hFFF2;
  localparam logic [15:0] c_vec_cmi  = 16'hFFEC;
  localparam logic [15:0] c_vec_sci  = 16'hFFF0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PEND = 2'd1,
    ST_GAP  = 2'd2
  } irq_state_t;

  function automatic logic [15:0] src_vec(input logic [2:0] code);
    logic [15:0] v;
    case (code)
      c_src_nmi:  v = c_vec_nmi;
      c_src_irq1: v = c_vec_irq1;
      c_src_ici:  v = c_vec_ici;
      c_src_oci:  v = c_vec_oci;
      c_src_toi:  v = c_vec_toi;
      c_src_cmi:  v = c_vec_cmi;
      c_src_sci:  v = c_vec_sci;
      default:    v = c_vec_none;
    endcase
    return v;
  endfunction

endpackage
`default_nettype wire

// File: rtl/hd63701_irq_prienc.sv
`default_nettype none
// ============================================================================
// Module   : hd63701_irq_prienc
// Purpose  : Combinational 7-input fixed-priority encoder; bit 0 (NMI) is
//            highest, bit 6 (SCI) lowest. Returns source code and vector.
// Revision : 1.0  initial release
// ============================================================================
module hd63701_irq_prienc
  import hd63701_irq_pkg::*;
(
  input  logic [6:0]  i_req,
  output logic        o_hit,
  output logic [2:0]  o_src,
  output logic [15:0] o_vec
);

  // Scan lowest priority first so the highest-priority hit overwrites last.
  always_comb begin
    o_src = c_src_none;
    for (int i = 6; i >= 0; i--) begin
      if (i_req[i]) begin
        o_src = 3'(i + 1);
      end
    end
  end

  assign o_hit = |i_req;
  assign o_vec = src_vec(o_src);

endmodule
`default_nettype wire

// File: rtl/hd63701_irq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : hd63701_irq_ctrl
// Purpose  : HD63701 interrupt controller: NMI edge latch, IRQ1/IRQ2 level
//            arbitration and IDLE/PEND/GAP request handshake with the core.
// Config   : define HD63701_IRQ_SCI_EN to let the serial source participate.
// Revision : 1.0  initial release
// ============================================================================
module hd63701_irq_ctrl
  import hd63701_irq_pkg::*;
(
  input  logic        mcu_clx2,
  input  logic        mcu_rst,
  input  logic        nmi,
  input  logic        irq1,
  input  logic        ici,
  input  logic        oci,
  input  logic        toi,
  input  logic        cmi,
  input  logic        sci,
  input  logic        imask,
  input  logic        ack,
  output logic        irq_req,
  output logic [15:0] irq_vec,
  output logic [2:0]  irq_src
);

  irq_state_t  r_state, w_state_nxt;
  logic [2:0]  r_src, w_src_nxt;
  logic [15:0] r_vec, w_vec_nxt;
  logic        r_nmi_prev;
  logic        r_nmi_pend, w_nmi_pend_nxt;

  logic        w_sci_lvl;
  logic [6:0]  w_lvl;
  logic [6:0]  w_elig;
  logic        w_hit;
  logic [2:0]  w_win_src;
  logic [15:0] w_win_vec;
  logic        w_win_lvl;
  logic        w_nmi_edge;

`ifdef HD63701_IRQ_SCI_EN
  assign w_sci_lvl = sci;
`else
  logic w_sci_unused;
  assign w_sci_unused = sci;
  assign w_sci_lvl    = 1'b0;
`endif

  assign w_nmi_edge = nmi & ~r_nmi_prev;

  // Bit 0 is the latched NMI; the rest are raw levels in priority order.
  assign w_lvl  = {w_sci_lvl, cmi, toi, oci, ici, irq1, r_nmi_pend};
  assign w_elig = {w_lvl[6:1] & {6{~imask}}, r_nmi_pend};

  hd63701_irq_prienc u_prienc (
    .i_req (w_elig),
    .o_hit (w_hit),
    .o_src (w_win_src),
    .o_vec (w_win_vec)
  );

  // Current level of the frozen winner, used to decide withdrawal.
  always_comb begin
    w_win_lvl = 1'b0;
    if (r_src != c_src_none) begin
      w_win_lvl = w_lvl[r_src - 3'd1];
    end
  end

  always_ff @(posedge mcu_clx2) begin
    if (mcu_rst) begin
      r_state    <= ST_IDLE;
      r_src      <= c_src_none;
      r_vec      <= c_vec_none;
      r_nmi_prev <= 1'b1;
      r_nmi_pend <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_src      <= w_src_nxt;
      r_vec      <= w_vec_nxt;
      r_nmi_prev <= nmi;
      r_nmi_pend <= w_nmi_pend_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_src_nxt      = r_src;
    w_vec_nxt      = r_vec;
    w_nmi_pend_nxt = r_nmi_pend | w_nmi_edge;
    case (r_state)
      ST_IDLE: begin
        if (w_hit) begin
          w_state_nxt = ST_PEND;
          w_src_nxt   = w_win_src;
          w_vec_nxt   = w_win_vec;
        end
      end
      ST_PEND: begin
        if (ack) begin
          w_state_nxt = ST_GAP;
          w_src_nxt   = c_src_none;
          w_vec_nxt   = c_vec_none;
          // An edge landing on the acknowledge cycle merges into the one served.
          if (r_src == c_src_nmi) begin
            w_nmi_pend_nxt = 1'b0;
          end
        end else if ((r_src != c_src_nmi) && (imask || !w_win_lvl)) begin
          w_state_nxt = ST_IDLE;
          w_src_nxt   = c_src_none;
          w_vec_nxt   = c_vec_none;
        end
      end
      ST_GAP: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_src_nxt   = c_src_none;
        w_vec_nxt   = c_vec_none;
      end
    endcase
  end

  assign irq_req = (r_state == ST_PEND);
  assign irq_src = r_src;
  assign irq_vec = r_vec;

endmodule
`default_nettype wire

// File: tb/tb_hd63701_irq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_hd63701_irq_ctrl
// Purpose  : Self-checking bench for hd63701_irq_ctrl: directed scenarios plus
//            randomized traffic against a cycle-level behavioural model.
// Revision : 1.0  initial release
// ============================================================================
module tb_hd63701_irq_ctrl;

  logic        mcu_clx2 = 1'b0;
  logic        mcu_rst, nmi, irq1, ici, oci, toi, cmi, sci, imask, ack;
  logic        irq_req;
  logic [15:0] irq_vec;
  logic [2:0]  irq_src;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 mcu_clx2 = ~mcu_clx2;

  hd63701_irq_ctrl dut (
    .mcu_clx2 (mcu_clx2),
    .mcu_rst  (mcu_rst),
    .nmi      (nmi),
    .irq1     (irq1),
    .ici      (ici),
    .oci      (oci),
    .toi      (toi),
    .cmi      (cmi),
    .sci      (sci),
    .imask    (imask),
    .ack      (ack),
    .irq_req  (irq_req),
    .irq_vec  (irq_vec),
    .irq_src  (irq_src)
  );

  // Behavioural model: requesting / gap flags, frozen winner, NMI latch.
  bit          m_req, m_gap, m_pend, m_prev;
  int          m_src;
  logic [15:0] m_vec_tab [8] = '{16'h0000, 16'hFFFC, 16'hFFF8, 16'hFFF6,
                                 16'hFFF4, 16'hFFF2, 16'hFFEC, 16'hFFF0};

  function automatic bit lvl(int s);
    case (s)
      2: return irq1;
      3: return ici;
      4: return oci;
      5: return toi;
      6: return cmi;
`ifdef HD63701_IRQ_SCI_EN
      7: return sci;
`endif
      default: return 1'b0;
    endcase
  endfunction

  function automatic void model_update();
    bit old_pend, edge_seen, clr;
    if (mcu_rst) begin
      m_req = 0; m_gap = 0; m_src = 0; m_pend = 0; m_prev = 1;
      return;
    end
    old_pend  = m_pend;
    edge_seen = nmi && !m_prev;
    m_prev    = nmi;
    clr       = 0;
    if (m_req) begin
      if (ack) begin
        clr   = (m_src == 1);
        m_req = 0; m_gap = 1; m_src = 0;
      end else if (m_src != 1 && (imask || !lvl(m_src))) begin
        m_req = 0; m_src = 0;
      end
    end else if (m_gap) begin
      m_gap = 0;
    end else begin
      for (int s = 1; s <= 7; s++) begin
        if (!m_req && ((s == 1) ? old_pend : (lvl(s) && !imask))) begin
          m_req = 1; m_src = s;
        end
      end
    end
    m_pend = clr ? 1'b0 : (old_pend || edge_seen);
  endfunction

  task automatic step();
    @(posedge mcu_clx2);
    model_update();
    #1;
  endtask

  task automatic clear_inputs();
    {nmi, irq1, ici, oci, toi, cmi, sci, imask, ack} = '0;
  endtask

  task automatic test_reset();
    clear_inputs();
    mcu_rst = 1;
    step(); step();
    n_tests++;
    if (irq_req !== 1'b0 || irq_src !== 3'd0 || irq_vec !== 16'h0000) begin
      n_fail++;
      $display("FAIL reset_state: req=%b src=%0d vec=%h, want 0/0/0000", irq_req, irq_src, irq_vec);
    end
    mcu_rst = 0;
    step();
    n_tests++;
    if (irq_req !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_idle: req=%b want 0", irq_req);
    end
  endtask

  task automatic test_toi();
    toi = 1;
    step();
    n_tests++;
    if (irq_req !== 1'b1 || irq_src !== 3'd5 || irq_vec !== 16'hFFF2) begin
      n_fail++;
      $display("FAIL toi_req: req=%b src=%0d vec=%h, want 1/5/fff2", irq_req, irq_src, irq_vec);
    end
    ack = 1;
    step();
    ack = 0;
    n_tests++;
    if (irq_req !== 1'b0 || irq_src !== 3'd0 || irq_vec !== 16'h0000) begin
      n_fail++;
      $display("FAIL toi_gap: req=%b src=%0d vec=%h, want 0/0/0000", irq_req, irq_src, irq_vec);
    end
    step();
    n_tests++;
    if (irq_req !== 1'b0) begin
      n_fail++;
      $display("FAIL toi_idle: req=%b want 0", irq_req);
    end
    step();
    n_tests++;
    if (irq_req !== 1'b1 || irq_src !== 3'd5) begin
      n_fail++;
      $display("FAIL toi_rereq: req=%b src=%0d, want 1/5", irq_req, irq_src);
    end
    toi = 0;
    step(); step();
  endtask

  task automatic test_irq1_sci();
    irq1 = 1; sci = 1;
    step();
    n_tests++;
    if (irq_src !== 3'd2 || irq_vec !== 16'hFFF8) begin
      n_fail++;
      $display("FAIL irq1_win: src=%0d vec=%h, want 2/fff8", irq_src, irq_vec);
    end
    ack = 1; irq1 = 0;
    step();
    ack = 0;
    step(); step();
    n_tests++;
`ifdef HD63701_IRQ_SCI_EN
    if (irq_req !== 1'b1 || irq_src !== 3'd7 || irq_vec !== 16'hFFF0) begin
      n_fail++;
      $display("FAIL sci_after: req=%b src=%0d vec=%h, want 1/7/fff0", irq_req, irq_src, irq_vec);
    end
`else
    if (irq_req !== 1'b0 || irq_src !== 3'd0) begin
      n_fail++;
      $display("FAIL sci_ignored: req=%b src=%0d, want 0/0", irq_req, irq_src);
    end
`endif
    sci = 0;
    step(); step();
  endtask

  task automatic test_nmi_preempt();
    oci = 1;
    step();
    nmi = 1;
    step(); step();
    n_tests++;
    if (irq_req !== 1'b1 || irq_src !== 3'd4) begin
      n_fail++;
      $display("FAIL oci_frozen: req=%b src=%0d, want 1/4", irq_req, irq_src);
    end
    ack = 1;
    step();
    ack = 0; oci = 0;
    step(); step();
    n_tests++;
    if (irq_req !== 1'b1 || irq_src !== 3'd1 || irq_vec !== 16'hFFFC) begin
      n_fail++;
      $display("FAIL nmi_next: req=%b src=%0d vec=%h, want 1/1/fffc", irq_req, irq_src, irq_vec);
    end
    ack = 1;
    step();
    ack = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      n_tests++;
      if (irq_req !== 1'b0) begin
        n_fail++;
        $display("FAIL nmi_cleared: cycle %0d req=%b want 0", i, irq_req);
      end
    end
  endtask

  // Entered with nmi still held high from the previous scenario.
  task automatic test_withdraw();
    cmi = 1;
    step();
    n_tests++;
    if (irq_req !== 1'b1 || irq_src !== 3'd6 || irq_vec !== 16'hFFEC) begin
      n_fail++;
      $display("FAIL cmi_req: req=%b src=%0d vec=%h, want 1/6/ffec", irq_req, irq_src, irq_vec);
    end
    imask = 1;
    step();
    n_tests++;
    if (irq_req !== 1'b0 || irq_src !== 3'd0) begin
      n_fail++;
      $display("FAIL cmi_withdraw: req=%b src=%0d, want 0/0", irq_req, irq_src);
    end
    cmi = 0; imask = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      n_tests++;
      if (irq_req !== 1'b0) begin
        n_fail++;
        $display("FAIL withdraw_no_nmi: cycle %0d req=%b want 0", i, irq_req);
      end
    end
    nmi = 0;
    step();
  endtask

  task automatic test_nmi_reset();
    nmi = 1; mcu_rst = 1;
    step();
    mcu_rst = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      n_tests++;
      if (irq_req !== 1'b0) begin
        n_fail++;
        $display("FAIL nmi_high_rst: cycle %0d req=%b want 0", i, irq_req);
      end
    end
    nmi = 0;
    step();
    nmi = 1;
    step(); step();
    n_tests++;
    if (irq_req !== 1'b1 || irq_src !== 3'd1) begin
      n_fail++;
      $display("FAIL nmi_edge_req: req=%b src=%0d, want 1/1", irq_req, irq_src);
    end
    ack = 1;
    step();
    ack = 0; nmi = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      n_tests++;
      if (irq_req !== 1'b0) begin
        n_fail++;
        $display("FAIL nmi_once: cycle %0d req=%b want 0", i, irq_req);
      end
    end
  endtask

  task automatic test_rst_pend();
    ici = 1;
    step();
    n_tests++;
    if (irq_req !== 1'b1 || irq_src !== 3'd3 || irq_vec !== 16'hFFF6) begin
      n_fail++;
      $display("FAIL ici_req: req=%b src=%0d vec=%h, want 1/3/fff6", irq_req, irq_src, irq_vec);
    end
    mcu_rst = 1;
    step();
    n_tests++;
    if (irq_req !== 1'b0 || irq_src !== 3'd0) begin
      n_fail++;
      $display("FAIL rst_abandon: req=%b src=%0d, want 0/0", irq_req, irq_src);
    end
    mcu_rst = 0; ici = 0;
    step();
    ack = 1;
    step();
    ack = 0;
    step();
    n_tests++;
    if (irq_req !== 1'b0) begin
      n_fail++;
      $display("FAIL ack_idle: req=%b want 0", irq_req);
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 2000; c++) begin
      mcu_rst = ($urandom_range(0, 199) == 0);
      if ($urandom_range(0, 9) == 0) nmi = ~nmi;
      irq1  = ($urandom_range(0, 5) == 0);
      ici   = ($urandom_range(0, 7) == 0);
      oci   = ($urandom_range(0, 7) == 0);
      toi   = ($urandom_range(0, 5) == 0);
      cmi   = ($urandom_range(0, 7) == 0);
      sci   = ($urandom_range(0, 4) == 0);
      imask = ($urandom_range(0, 4) == 0);
      ack   = ($urandom_range(0, 3) == 0);
      step();
      n_tests++;
      if (irq_req !== m_req || irq_src !== 3'(m_src) || irq_vec !== m_vec_tab[m_src]) begin
        n_fail++;
        $display("FAIL random c=%0d: req=%b src=%0d vec=%h, want %b/%0d/%h",
                 c, irq_req, irq_src, irq_vec, m_req, m_src, m_vec_tab[m_src]);
      end
    end
    clear_inputs();
    mcu_rst = 0;
  endtask

  initial begin
    mcu_rst = 1;
    clear_inputs();
    m_req = 0; m_gap = 0; m_pend = 0; m_prev = 1; m_src = 0;
    test_reset();
    test_toi();
    test_irq1_sci();
    test_nmi_preempt();
    test_withdraw();
    test_nmi_reset();
    test_rst_pend();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
